cla_accumulator_8bits: RTL and testbench
========================================

Name: cla_accumulator_8bits

Overview:
Sequential operand accumulator that sits directly upstream of, and wraps, the 8-bit carry-lookahead adder. It accepts a stream of 8-bit operands over a valid/ready handshake and feeds each operand plus the running total into the adder. It registers the adder's sum and carry-out. When the last operand of a frame is accepted, it presents the frame total, a carry count and an overflow flag to a downstream consumer.

Parameters:
WIDTH, 8, operand and accumulator width; must match the adder width (only 8 supported).
CNT_W, 4, width of the carry-out counter; saturates at 2^CNT_W-1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand on in_data is valid.
in_ready  output  1  block can accept an operand this cycle.
in_data  input  WIDTH  operand.
in_last  input  1  qualifies in_data as the final operand of the frame.
out_valid  output  1  frame result is valid.
out_ready  input  1  downstream accepts the result.
out_sum  output  WIDTH  accumulated total, modulo 2^WIDTH unless ACC_SATURATE_EN is defined.
out_carries  output  CNT_W  number of adder carry-outs during the frame.
out_overflow  output  1  at least one carry-out occurred during the frame.

Behaviour:
- Reset: one clock; asynchronous active-low reset rst_n. While rst_n=0: state=IDLE, acc=0, carry count=0, ovf=0, in_ready=0, out_valid=0, out_sum=0, out_carries=0, out_overflow=0.
- in_ready is 1 in IDLE and ACCUM and 0 in HOLD. It is a registered state decode with no combinational path from out_ready.
- Adder hookup: s1=acc, s2=in_data, cin=0.
- States and transitions:
  - IDLE: acc=0, count=0. An accept (in_valid && in_ready) loads acc<=in_data; the carry is 0 by construction. Next state is HOLD if in_last, else ACCUM.
  - ACCUM: an accept sets acc<=sum and adds cout to count, saturating at 2^CNT_W-1. ovf|=cout. Next state is HOLD if in_last, else stays ACCUM. With no accept, all registers hold.
  - HOLD: out_valid=1. out_sum, out_carries and out_overflow are stable and equal the frame result. When out_ready=1, the next state is IDLE and acc, count and ovf clear. out_valid stays asserted until that handshake.
- Latency: the result is visible one cycle after the in_last accept. A single-operand frame gives out_sum=in_data and out_carries=0.
- Throughput: one operand per cycle. One idle-input cycle minimum between frames, because HOLD is always at least one cycle.
- Wrap-around: without the optional feature, the sum wraps modulo 256 and each wrap counts as one carry.
- Outputs are valid only while out_valid=1. Values when out_valid=0 are don't-care but are driven from registers (no X).
- Reset mid-frame: the partial accumulation is discarded and the block returns to IDLE.

Optional Feature:
ACC_SATURATE_EN.
- Defined: on any carry-out, acc<=8'hFF and stays at 8'hFF for the rest of the frame. out_carries and out_overflow still count and flag carries as normal.
- Undefined: plain modulo-256 wrap.

Decomposition:
- Package cla_acc_pkg holds:
  - enum state_t {IDLE, ACCUM, HOLD}, 2-bit encoding;
  - localparam ACC_W=8;
  - localparam CNT_MAX.
- One sub-module, instantiated once: carry_loockahead_adder_8bits, the existing combinational adder. The accumulator adds no other arithmetic.

Test Plan:
- Reset check: with rst_n low, all outputs are 0. After release, in_ready=1 next cycle and out_valid=0.
- Frame 10,20,30 (last on 30), out_ready=1 → out_valid for one cycle with out_sum=60, out_carries=0, out_overflow=0.
- Frame 200,100,250 (last on 250) → out_sum=38, out_carries=2, out_overflow=1. With ACC_SATURATE_EN: out_sum=255, out_carries=2, out_overflow=1.
- Backpressure: single-operand frame 8'h55 with last=1 and out_ready=0 for 5 cycles → out_valid held, out_sum=8'h55 stable, in_ready=0 throughout; result accepted on the cycle out_ready=1.
- Saturating counter: 20 operands of 8'hFF with last on the 20th → out_carries=15 (saturated), out_overflow=1; out_sum=8'hEC without the feature, 8'hFF with it.
- Reset mid-frame: feed 50 then 60 without last, pulse rst_n low, then send frame {7 with last} → out_sum=7, out_carries=0.

Source files
------------

// File: rtl/cla_acc_pkg.sv
// Shared types and constants for the carry-lookahead operand accumulator.
package cla_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int ACC_W     = 8;
    localparam int CNT_W_DEF = 4;
    localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

endpackage

// File: rtl/carry_loockahead_adder_8bits.sv
// 8-bit combinational carry-lookahead adder built from two 4-bit lookahead
// groups; the group carries are themselves resolved by lookahead.
module carry_loockahead_adder_8bits (
    input  logic [7:0] s1,
    input  logic [7:0] s2,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;
    logic [1:0] grp_g;
    logic [1:0] grp_p;
    logic [1:0] grp_cin;

    assign g = s1 & s2;
    assign p = s1 ^ s2;

    assign grp_cin[0] = cin;
    assign grp_cin[1] = grp_g[0] | (grp_p[0] & cin);
    assign cout       = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);

    for (genvar grp = 0; grp < 2; grp++) begin : g_grp
        localparam int B = 4 * grp;

        assign c[B]   = grp_cin[grp];
        assign c[B+1] = g[B] | (p[B] & grp_cin[grp]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_cin[grp]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & grp_cin[grp]);

        assign grp_g[grp] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grp_p[grp] = &p[B+3:B];
    end

    assign sum = p ^ c;

endmodule

// File: rtl/cla_accumulator_8bits.sv
// Frame accumulator wrapped around the 8-bit CLA: sums a valid/ready operand stream
// and holds the total, carry count and overflow flag. Optional macro: ACC_SATURATE_EN.
module cla_accumulator_8bits
    import cla_acc_pkg::*;
#(
    parameter int WIDTH = ACC_W,   // only 8 is supported by the adder
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_carries,
    output logic             out_overflow
);

    localparam logic [CNT_W-1:0] CNT_LIM = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf;
    logic             ovf_d;
    logic             ready_q;
    logic             valid_q;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             accept;

    carry_loockahead_adder_8bits u_adder (
        .s1   (acc),
        .s2   (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept = in_valid && ready_q;

    // State and datapath registers; handshake flags are decoded from the
    // next state so neither carries a combinational path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            cnt     <= cnt_d;
            ovf     <= ovf_d;
            ready_q <= (state_d != HOLD);
            valid_q <= (state_d == HOLD);
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = in_last ? HOLD : ACCUM;
            ACCUM:   if (accept) state_d = in_last ? HOLD : ACCUM;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc;
        cnt_d = cnt;
        ovf_d = ovf;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_d = in_data;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            end
            ACCUM: begin
                if (accept) begin
`ifdef ACC_SATURATE_EN
                    // once a carry has been seen the total pins at all-ones
                    acc_d = (add_cout || ovf) ? '1 : add_sum;
`else
                    acc_d = add_sum;
`endif
                    if (add_cout && (cnt != CNT_LIM)) cnt_d = cnt + CNT_W'(1);
                    ovf_d = ovf | add_cout;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
            end
            default: begin
                acc_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end
        endcase
    end

    assign in_ready     = ready_q;
    assign out_valid    = valid_q;
    assign out_sum      = acc;
    assign out_carries  = cnt;
    assign out_overflow = ovf;

endmodule

// File: tb/tb_cla_accumulator_8bits.sv
// Directed bench for cla_accumulator_8bits; expectations follow ACC_SATURATE_EN.
module tb_cla_accumulator_8bits;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic [3:0] out_carries;
    logic       out_overflow;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cla_accumulator_8bits dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carries  (out_carries),
        .out_overflow (out_overflow)
    );

    // Present one operand and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL send_timeout got in_ready=%0b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_sum, out_carries, out_overflow} !== 15'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {in_ready, out_valid, out_sum, out_carries, out_overflow});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got ready=%0b valid=%0b exp ready=1 valid=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_basic_frame;
        out_ready = 1'b1;
        send(8'd10, 1'b0);
        send(8'd20, 1'b0);
        send(8'd30, 1'b1);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_sum !== 8'd60 || out_carries !== 4'd0 || out_overflow !== 1'b0) begin
            bad++;
            $display("FAIL basic_result got v=%0b sum=%0d c=%0d o=%0b exp v=1 sum=60 c=0 o=0",
                     out_valid, out_sum, out_carries, out_overflow);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_one_cycle got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_sum;
`ifdef ACC_SATURATE_EN
        exp_sum = 8'd255;
`else
        exp_sum = 8'd38;
`endif
        out_ready = 1'b1;
        send(8'd200, 1'b0);
        send(8'd100, 1'b0);
        send(8'd250, 1'b1);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_sum !== exp_sum || out_carries !== 4'd2 || out_overflow !== 1'b1) begin
            bad++;
            $display("FAIL wrap_result got v=%0b sum=%0d c=%0d o=%0b exp v=1 sum=%0d c=2 o=1",
                     out_valid, out_sum, out_carries, out_overflow, exp_sum);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send(8'h55, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_sum !== 8'h55 || in_ready !== 1'b0 || out_carries !== 4'd0) begin
                bad++;
                $display("FAIL bp_hold%0d got v=%0b sum=%h r=%0b c=%0d exp v=1 sum=55 r=0 c=0",
                         i, out_valid, out_sum, in_ready, out_carries);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got v=%0b r=%0b exp v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_sat_counter;
        logic [7:0] exp_sum;
`ifdef ACC_SATURATE_EN
        exp_sum = 8'hFF;
`else
        exp_sum = 8'hEC;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(8'hFF, (i == 19));
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_sum !== exp_sum || out_carries !== 4'd15 || out_overflow !== 1'b1) begin
            bad++;
            $display("FAIL satcnt_result got v=%0b sum=%h c=%0d o=%0b exp v=1 sum=%h c=15 o=1",
                     out_valid, out_sum, out_carries, out_overflow, exp_sum);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        out_ready = 1'b1;
        send(8'd50, 1'b0);
        send(8'd60, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        total++;
        if (out_sum !== 8'd0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_clear got sum=%0d r=%0b v=%0b exp sum=0 r=0 v=0",
                     out_sum, in_ready, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd7, 1'b1);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_sum !== 8'd7 || out_carries !== 4'd0 || out_overflow !== 1'b0) begin
            bad++;
            $display("FAIL midrst_result got v=%0b sum=%0d c=%0d o=%0b exp v=1 sum=7 c=0 o=0",
                     out_valid, out_sum, out_carries, out_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_wrap();
        @(negedge clk);
        test_backpressure();
        test_sat_counter();
        test_reset_mid_frame();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
